// File: rtl/game_round_scheduler.sv
// Guess-the-sum game sequencer: shows `rounds` random numbers, opens a timed
// answer window, then shows the result before returning to idle.
module game_round_scheduler #(
  parameter int NUM_HOLD = 5,
  parameter int ANS_WIN  = 15,
  parameter int RES_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] rounds_in,
  input  logic [4:0] rand_val,
  output logic       lfsr_step,
  input  logic [6:0] answer,
  input  logic       submit,
  output logic [7:0] disp_val,
  output logic [6:0] led,
  output logic [1:0] state,
  output logic       correct,
  output logic       done
);

  localparam int MAX_A    = (NUM_HOLD > ANS_WIN) ? NUM_HOLD : ANS_WIN;
  localparam int MAX_HOLD = (MAX_A > RES_HOLD) ? MAX_A : RES_HOLD;
  localparam int CW       = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] NUM_LAST = CW'(NUM_HOLD - 1);
  localparam logic [CW-1:0] ANS_LAST = CW'(ANS_WIN - 1);
  localparam logic [CW-1:0] RES_LAST = CW'(RES_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GEN    = 2'd1,
    S_ANSWER = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t          r_state, w_state_next;
  logic [2:0]      r_rounds, w_rounds_next;
  logic [2:0]      r_round_cnt, w_round_cnt_next;
  logic [CW-1:0]   r_cyc, w_cyc_next;
  logic [7:0]      r_sum, w_sum_next;
  logic [4:0]      r_num, w_num_next;
  logic [7:0]      r_disp, w_disp_next;
  logic [6:0]      r_led, w_led_next;
  logic            r_correct, w_correct_next;
  logic            r_done, w_done_next;

  logic [2:0]      w_clamp;
  logic [6:0]      w_sum_mod;
  logic            w_match;
  logic            w_gen_wrap;
  logic            w_gen_end;
  logic            w_ans_end;
  logic            w_res_last;

  assign w_clamp    = (rounds_in < 3'd3) ? 3'd3 : rounds_in;
  assign w_gen_wrap = (r_cyc == NUM_LAST);
  assign w_gen_end  = w_gen_wrap && ((r_round_cnt + 3'd1) == r_rounds);
  assign w_ans_end  = submit || (r_cyc == ANS_LAST);
  assign w_res_last = (r_cyc == RES_LAST);

  // sum never exceeds 217, so two conditional subtractions give mod 100
  always_comb begin
    w_sum_mod = r_sum[6:0];
    if (r_sum >= 8'd200)      w_sum_mod = 7'(r_sum - 8'd200);
    else if (r_sum >= 8'd100) w_sum_mod = 7'(r_sum - 8'd100);
  end

  // mod result is below 100, so answers above 99 can never match
  assign w_match   = (answer == w_sum_mod);
  assign lfsr_step = !rst && (r_state == S_GEN) && (r_cyc == '0);
  assign state     = r_state;
  assign disp_val  = r_disp;
  assign led       = r_led;
  assign correct   = r_correct;
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start)      w_state_next = S_GEN;
      S_GEN:    if (w_gen_end)  w_state_next = S_ANSWER;
      S_ANSWER: if (w_ans_end)  w_state_next = S_RESULT;
      S_RESULT: if (w_res_last) w_state_next = S_IDLE;
      default:                  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rounds_next    = r_rounds;
    w_round_cnt_next = r_round_cnt;
    w_cyc_next       = r_cyc;
    w_sum_next       = r_sum;
    w_num_next       = r_num;
    w_disp_next      = r_disp;
    w_led_next       = r_led;
    w_correct_next   = r_correct;
    case (r_state)
      S_IDLE: begin
        w_disp_next = {5'b0, w_clamp};
        w_led_next  = {w_clamp, 4'b0};
        if (start) begin
          w_rounds_next    = w_clamp;
          w_sum_next       = 8'd0;
          w_round_cnt_next = 3'd0;
          w_cyc_next       = '0;
        end
      end
      S_GEN: begin
        if (r_cyc == '0) begin
          w_num_next  = rand_val;
          w_disp_next = {3'b0, rand_val};
          w_led_next  = {rand_val, 2'b0};
          w_sum_next  = r_sum + {3'b0, rand_val};
        end
        if (w_gen_wrap) begin
          w_cyc_next       = '0;
          w_round_cnt_next = r_round_cnt + 3'd1;
        end else begin
          w_cyc_next = r_cyc + CW'(1);
        end
      end
      S_ANSWER: begin
        // the result display is loaded on the closing edge so RESULT shows it from its first cycle
        if (w_ans_end) begin
          w_correct_next = w_match;
          w_disp_next    = {1'b0, w_sum_mod};
          w_led_next     = w_match ? 7'h7F : 7'b1010101;
          w_cyc_next     = '0;
        end else begin
          w_disp_next = {1'b0, answer};
          w_led_next  = 7'd0;
          w_cyc_next  = r_cyc + CW'(1);
        end
      end
      S_RESULT: begin
        w_disp_next = {1'b0, w_sum_mod};
        w_led_next  = r_correct ? 7'h7F : 7'b1010101;
        if (w_res_last) begin
          w_cyc_next     = '0;
          w_correct_next = 1'b0;
        end else begin
          w_cyc_next = r_cyc + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign w_done_next = (w_state_next == S_RESULT) && (w_cyc_next == RES_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rounds    <= 3'd3;
      r_round_cnt <= 3'd0;
      r_cyc       <= '0;
      r_sum       <= 8'd0;
      r_num       <= 5'd0;
      r_disp      <= 8'd0;
      r_led       <= 7'd0;
      r_correct   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rounds    <= w_rounds_next;
      r_round_cnt <= w_round_cnt_next;
      r_cyc       <= w_cyc_next;
      r_sum       <= w_sum_next;
      r_num       <= w_num_next;
      r_disp      <= w_disp_next;
      r_led       <= w_led_next;
      r_correct   <= w_correct_next;
      r_done      <= w_done_next;
    end
  end

endmodule

// File: tb/tb_game_round_scheduler.sv
// Directed bench for game_round_scheduler: full games with hand-computed
// sums, timeout/submit races, ignored inputs and mid-game reset.
module tb_game_round_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] rounds_in;
  logic [4:0] rand_val;
  logic       lfsr_step;
  logic [6:0] answer;
  logic       submit;
  logic [7:0] disp_val;
  logic [6:0] led;
  logic [1:0] state;
  logic       correct;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] rtab [7];

  game_round_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .rounds_in(rounds_in),
    .rand_val(rand_val), .lfsr_step(lfsr_step), .answer(answer),
    .submit(submit), .disp_val(disp_val), .led(led), .state(state),
    .correct(correct), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One complete game; all expectations are supplied by the caller.
  task automatic play(input int rin, input int exp_rounds, input int ans, input int sub_at,
                      input bit noise, input int exp_mod, input int exp_corr);
    int gen, steps, last, gapbad, a, r, dcnt, dpos;
    rounds_in = 3'(rin);
    tick();
    check("idle_disp", disp_val, exp_rounds);
    check("idle_led", led, exp_rounds * 16);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("enter_gen", state, 1);
    gen = 0; steps = 0; last = 0; gapbad = 0;
    while (state == 2'd1 && gen < 100) begin
      if (gen == 1) begin
        check("gen_disp", disp_val, rtab[0]);
        check("gen_led", led, rtab[0] * 4);
      end
      rand_val = rtab[steps % 7];
      if (noise) begin
        start  = gen[0];
        submit = ~gen[0];
        if (gen == 3) rounds_in = 3'd7;
      end
      if (lfsr_step) begin
        if (steps > 0 && gen - last != 5) gapbad++;
        last = gen;
        steps++;
      end
      tick();
      gen++;
    end
    start = 1'b0; submit = 1'b0;
    check("gen_cycles", gen, exp_rounds * 5);
    check("lfsr_steps", steps, exp_rounds);
    check("step_spacing", gapbad, 0);
    check("enter_answer", state, 2);
    answer = 7'(ans);
    a = 0;
    while (state == 2'd2 && a < 50) begin
      if (a == 1) check("ans_disp", disp_val, ans);
      if (lfsr_step) check("step_in_answer", lfsr_step, 0);
      submit = (a == sub_at);
      if (noise) start = ~a[0];
      tick();
      a++;
    end
    submit = 1'b0; start = 1'b0;
    check("answer_cycles", a, (sub_at >= 0) ? sub_at + 1 : 15);
    check("enter_result", state, 3);
    check("res_disp", disp_val, exp_mod);
    check("res_led", led, exp_corr ? 32'h7F : 32'h55);
    check("res_correct", correct, exp_corr);
    r = 0; dcnt = 0; dpos = -1;
    while (state == 2'd3 && r < 20) begin
      if (done) begin dcnt++; dpos = r; end
      tick();
      r++;
    end
    check("result_cycles", r, 4);
    check("done_count", dcnt, 1);
    check("done_pos", dpos, 3);
    check("back_idle", state, 0);
    check("idle_correct_clr", correct, 0);
    check("idle_done_low", done, 0);
    $display("[TB] game rounds_in=%0d answer=%0d disp=%0d correct=%0d", rin, ans, exp_mod, exp_corr);
  endtask

  initial begin
    int s;
    rst = 1'b1; start = 1'b0; rounds_in = 3'd0; rand_val = 5'd0;
    answer = 7'd0; submit = 1'b0;
    tick(); tick(); tick();
    check("rst_state", state, 0);
    check("rst_disp", disp_val, 0);
    check("rst_led", led, 0);
    check("rst_correct", correct, 0);
    check("rst_done", done, 0);
    check("rst_step", lfsr_step, 0);
    rst = 1'b0;
    tick();

    // 3 rounds (clamped from 1): 10+20+30=60, submitted answer 60
    rtab = '{5'd10, 5'd20, 5'd30, 5'd0, 5'd0, 5'd0, 5'd0};
    play(1, 3, 60, 2, 1'b0, 60, 1);

    // 7 rounds of 31: sum 217 -> 17, timeout
    rtab = '{5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
    play(7, 7, 17, -1, 1'b0, 17, 1);

    // 4 rounds summing to 50, wrong answer submitted on the timeout cycle
    rtab = '{5'd5, 5'd10, 5'd15, 5'd20, 5'd0, 5'd0, 5'd0};
    play(4, 4, 51, 14, 1'b0, 50, 0);

    // clamp 2->3, start/submit noise and rounds_in change mid-game: sum 1+2+3=6
    rtab = '{5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0};
    play(2, 3, 6, 3, 1'b1, 6, 1);
    tick();
    check("noise_no_restart", state, 0);
    check("idle_tracks_7", disp_val, 7);

    // zero random values, answer 100 against sum 0
    rtab = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    play(3, 3, 100, 0, 1'b0, 0, 0);

    // reset at the start of round 2
    rounds_in = 3'd5; rand_val = 5'd9;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("pre_rst_state", state, 1);
    check("pre_rst_step", lfsr_step, 1);
    rst = 1'b1;
    #1;
    check("step_masked_rst", lfsr_step, 0);
    tick();
    check("mid_rst_state", state, 0);
    check("mid_rst_disp", disp_val, 0);
    check("mid_rst_led", led, 0);
    check("mid_rst_correct", correct, 0);
    check("mid_rst_done", done, 0);
    s = 0;
    rst = 1'b0;
    repeat (4) begin
      if (lfsr_step) s++;
      tick();
    end
    check("post_rst_steps", s, 0);
    check("post_rst_idle", state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
